// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, downstream hold,
// flush, and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [3:0]        id_alu_op,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [3:0]        ex_alu_op,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              stall_id,
    output logic [15:0]       bubble_cnt
);

    logic load_use;

    always_comb begin
        load_use = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                   ((ex_rd == id_rs) | (id_rt_used & (ex_rd == id_rt)));
        stall_id = (load_use | ex_stall) & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_alu_op   <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            bubble_cnt  <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else if (ex_stall) begin
            // hold every EX field, including the bubble count
        end else if (load_use) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 16'd1;
        end else begin
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
            ex_alu_op   <= id_alu_op;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread  & id_valid;
            ex_memwrite <= id_memwrite & id_valid;
            ex_memtoreg <= id_memtoreg & id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/saturation scenarios plus
// randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          id_rt_used = 1'b0;
    logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc = '0;
    logic [3:0]    id_alu_op = '0;
    logic          id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0, id_memtoreg = 1'b0;
    logic          ex_stall = 1'b0, flush = 1'b0;

    logic          ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic [3:0]    ex_alu_op;
    logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic          stall_id;
    logic [15:0]   bubble_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_alu_op(id_alu_op), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_alu_op(ex_alu_op), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what EX must contain, whether its data fields are meaningful,
    // and the bubble tally.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rs_data, rt_data, imm, pc;
        logic [3:0]    alu_op;
        logic          rw, mr, mw, mt;
    } ex_t;

    ex_t         m = '0;
    bit          m_known = 1'b1;
    int unsigned m_cnt = 0;

    function automatic bit model_hazard();
        return m.valid && m.mr && (m.rd != 0) && id_valid &&
               ((m.rd == id_rs) || (id_rt_used && (m.rd == id_rt)));
    endfunction

    always @(posedge clk) begin
        bit hz;
        hz = model_hazard();
        if (rst) begin
            m = '0; m_known = 1'b1; m_cnt = 0;
        end else if (flush) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mt = 0; m_known = 1'b0;
        end else if (ex_stall) begin
            m = m;
        end else if (hz) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mt = 0; m_known = 1'b0;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        end else begin
            m.valid = id_valid; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
            m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm; m.pc = id_pc;
            m.alu_op = id_alu_op;
            m.rw = id_valid && id_regwrite; m.mr = id_valid && id_memread;
            m.mw = id_valid && id_memwrite; m.mt = id_valid && id_memtoreg;
            m_known = id_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ex_valid", 32'(ex_valid), 32'(m.valid));
            cmp("ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
                32'({m.rw, m.mr, m.mw, m.mt}));
            cmp("bubble_cnt", 32'(bubble_cnt), m_cnt);
            cmp("stall_id", 32'(stall_id), 32'((model_hazard() || ex_stall) && !flush));
            if (m_known) begin
                cmp("spec", 32'({ex_rs, ex_rt, ex_rd, ex_alu_op}), 32'({m.rs, m.rt, m.rd, m.alu_op}));
                cmp("ops", {ex_rs_data, ex_rt_data}, {m.rs_data, m.rt_data});
                cmp("imm_pc", {ex_imm, ex_pc}, {m.imm, m.pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic rtu, input logic mr, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rt_used = rtu;
        id_memread = mr; id_regwrite = rw; id_memwrite = 1'b0; id_memtoreg = mr;
        id_rs_data = DW'($urandom); id_rt_data = DW'($urandom);
        id_imm = DW'($urandom); id_pc = DW'($urandom); id_alu_op = 4'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        cmp("rst_valid", 32'(ex_valid), 0);
        cmp("rst_cnt", 32'(bubble_cnt), 0);
        cmp("rst_rd", 32'(ex_rd), 0);
        cmp("rst_stall", 32'(stall_id), 0);
        rst = 1'b0;

        // normal flow
        set_id(1, 1, 2, 3, 1, 0, 1);
        id_rs_data = 16'h1234;
        tick();
        cmp("nf_rd", 32'(ex_rd), 3);
        cmp("nf_data", 32'(ex_rs_data), 32'h1234);
        cmp("nf_rw", 32'(ex_regwrite), 1);
        cmp("nf_valid", 32'(ex_valid), 1);

        // single load-use costs one bubble
        set_id(1, 1, 2, 5, 1, 1, 1);
        tick();
        set_id(1, 5, 2, 6, 1, 0, 1);
        #1 cmp("lu_stall", 32'(stall_id), 1);
        tick();
        cmp("lu_bubble", 32'(ex_valid), 0);
        cmp("lu_cnt", 32'(bubble_cnt), 1);
        cmp("lu_stall_off", 32'(stall_id), 0);
        tick();
        cmp("lu_enter", 32'(ex_valid), 1);
        cmp("lu_rd", 32'(ex_rd), 6);

        // no false stalls
        set_id(1, 1, 2, 5, 1, 1, 1);
        tick();
        set_id(1, 1, 5, 0, 0, 1, 0);
        #1 cmp("nofs_rt", 32'(stall_id), 0);
        tick();
        cmp("nofs_valid", 32'(ex_valid), 1);
        cmp("nofs_cnt", 32'(bubble_cnt), 1);
        set_id(1, 0, 0, 4, 1, 0, 1);
        #1 cmp("nofs_r0", 32'(stall_id), 0);
        tick();
        cmp("nofs_r0_cnt", 32'(bubble_cnt), 1);

        // flush beats stall and load-use
        set_id(1, 1, 2, 5, 1, 1, 1);
        tick();
        set_id(1, 5, 2, 7, 1, 0, 1);
        ex_stall = 1'b1; flush = 1'b1;
        #1 cmp("fl_stall", 32'(stall_id), 0);
        tick();
        cmp("fl_valid", 32'(ex_valid), 0);
        cmp("fl_ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 0);
        cmp("fl_cnt", 32'(bubble_cnt), 1);
        ex_stall = 1'b0; flush = 1'b0;

        // hold for three cycles, then release
        set_id(1, 1, 2, 7, 1, 0, 1);
        id_rs_data = 16'hABCD; id_alu_op = 4'd9;
        tick();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1);
            tick();
            cmp("hold_rd", 32'(ex_rd), 7);
            cmp("hold_data", 32'(ex_rs_data), 32'hABCD);
            cmp("hold_op", 32'(ex_alu_op), 9);
        end
        ex_stall = 1'b0;
        set_id(1, 1, 2, 8, 1, 0, 1);
        tick();
        cmp("rel_rd", 32'(ex_rd), 8);

        // saturation from a preloaded count
        @(negedge clk);
        #1;
        force dut.bubble_cnt = 16'hFFFE;
        m_cnt = 32'hFFFE;
        #1 release dut.bubble_cnt;
        for (int i = 0; i < 2; i++) begin
            set_id(1, 1, 2, 5, 1, 1, 1);
            tick();
            set_id(1, 5, 2, 6, 1, 0, 1);
            tick();
            cmp("sat_cnt", 32'(bubble_cnt), 32'hFFFF);
        end

        // reset mid-stall discards held contents
        set_id(1, 1, 2, 9, 1, 1, 1);
        tick();
        ex_stall = 1'b1; rst = 1'b1;
        tick();
        cmp("rs_valid", 32'(ex_valid), 0);
        cmp("rs_rd", 32'(ex_rd), 0);
        cmp("rs_data", 32'(ex_rs_data), 0);
        cmp("rs_cnt", 32'(bubble_cnt), 0);
        rst = 1'b0; ex_stall = 1'b0;
        set_id(1, 3, 4, 10, 1, 0, 1);
        tick();
        cmp("rs_reload", 32'(ex_valid), 1);
        cmp("rs_reload_rd", 32'(ex_rd), 10);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 4000; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            id_memwrite = 1'($urandom);
            ex_stall = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 16, datapath and PC width.
REQ-002 Parameter REG_AW, 4, register-specifier width; register 0 is hardwired zero.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  in  REG_AW each  source and destination specifiers.
REQ-007 id_rt_used  in  1  instruction reads rt (0 for immediate forms).
REQ-008 id_rs_data, id_rt_data, id_imm, id_pc  in  DATA_W each  operands, immediate and PC from ID.
REQ-009 id_alu_op  in  4  ALU opcode.
REQ-010 id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits.
REQ-011 ex_stall  in  1  downstream hold request; stage keeps contents.
REQ-012 flush  in  1  taken branch/redirect; kill instruction entering EX.
REQ-013 ex_valid  out  1  EX holds a real instruction.
REQ-014 ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc, ex_alu_op, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  same widths as ID counterparts  registered copies, feeding EX-stage forwarding and ALU.
REQ-015 stall_id  out  1  combinational; ID and PC must hold this cycle.
REQ-016 bubble_cnt  out  16  saturating count of inserted load-use bubbles.

Function
REQ-017 load_use SHALL be ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_rt_used & ex_rd == id_rt)), combinational.
REQ-018 stall_id SHALL equal (load_use | ex_stall) & ~flush.
REQ-019 Per-edge priority SHALL be: rst, then flush, then ex_stall, then load_use, then normal load.
REQ-020 flush: ex_valid <= 0 and ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg <= 0; flush overrides ex_stall and load_use in the same cycle.
REQ-021 ex_stall (no flush): every ex_* register holds its value; bubble_cnt unchanged even if load_use is high.
REQ-022 load_use (no flush, no ex_stall): insert bubble, i.e. ex_valid and the four control bits <= 0; data/specifier fields may load but SHALL be don't-care; bubble_cnt increments.
REQ-023 Normal load: all ex_* <= id_* and ex_valid <= id_valid; if id_valid=0 control bits SHALL load as 0.
REQ-024 Latency: one cycle from ID inputs to ex_* outputs when no stall.
REQ-025 A single load-use SHALL cost exactly one bubble: after the bubble ex_memread=0, so load_use deasserts and the held ID instruction loads next cycle.
REQ-026 Back-to-back loads with dependency SHALL each incur one bubble; no bubble when ex_rd=0 or when only rt matches with id_rt_used=0.
REQ-027 bubble_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-028 Invalid (bubble) EX contents SHALL never assert ex_regwrite, ex_memread or ex_memwrite.

Reset
REQ-029 On rst=1 at an edge: ex_valid, all control bits, ex_alu_op, all specifiers, all data fields and bubble_cnt SHALL become 0.
REQ-030 rst SHALL override flush, ex_stall and load_use; stall_id SHALL be 0 while ex_valid=0 after reset.
REQ-031 Reset asserted mid-stall SHALL discard held instruction; first edge after deassert performs normal load.

Verification
REQ-032 Normal flow: id_rd=3, id_rs_data=16'h1234, id_regwrite=1, valid -> next cycle ex_rd=3, ex_rs_data=16'h1234, ex_regwrite=1, ex_valid=1.
REQ-033 Load-use: EX holds load ex_rd=5 memread=1; ID id_rs=5 -> stall_id=1, next cycle ex_valid=0, bubble_cnt=1; following cycle ID instruction enters EX, stall_id=0.
REQ-034 No false stall: EX load ex_rd=5; ID id_rt=5, id_rt_used=0 -> stall_id=0, no bubble; ex_rd=0 load with id_rs=0 -> no bubble.
REQ-035 Flush vs stall: ex_stall=1, flush=1, load_use=1 same cycle -> ex_valid=0, controls 0, stall_id=0, bubble_cnt unchanged.
REQ-036 Hold: ex_stall=1 for 3 cycles with changing ID inputs -> all ex_* constant; release -> current ID loads.
REQ-037 Saturation/reset: preload bubble_cnt to 16'hFFFE, two load-use bubbles -> 16'hFFFF and stays; rst during stall -> all outputs 0 next edge.
